// File: rtl/ame_linear_solver.sv
// Sequential N x N linear-system solver (fraction-free Gauss-Jordan with partial pivoting).
// Solves A.x = b for a run-time selected size n and returns x in signed fixed point.
// A single restoring divider serves both the elimination and the final solve.
module ame_linear_solver #(
  parameter int unsigned N         = 6,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ACC_BITS  = 64,
  parameter int unsigned FRAC_BITS = 16,
  localparam int unsigned IW       = $clog2(N + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 start_i,
  input  logic [IW-1:0]                        size_i,
  input  logic [N-1:0][N:0][DATA_BITS-1:0]     mat_i,
  output logic                                 ready_o,
  output logic                                 done_o,
  output logic                                 singular_o,
  output logic [N-1:0][ACC_BITS-1:0]           x_o
);

  localparam int unsigned DIV_W = ACC_BITS + FRAC_BITS;
  localparam int unsigned D     = DIV_W + 2;
  localparam int unsigned CW    = $clog2(D);
  localparam int unsigned PW    = 2 * ACC_BITS;

  typedef enum logic [2:0] {
    StIdle, StLoad, StPivot, StSwap, StElim, StSolve, StDone
  } state_e;

  state_e state_q, state_d;

  // Matrix: columns 0..N-1 hold A, column N holds b
  logic signed [ACC_BITS-1:0] a_q [N][N+1];
  logic signed [ACC_BITS-1:0] prev_piv_q;

  logic [IW-1:0]        n_q, k_q, scan_q, best_row_q, i_q, j_q;
  logic [ACC_BITS-1:0]  best_mag_q;
  logic                 sing_q;
  logic [N-1:0][ACC_BITS-1:0] x_q;

  // Divider state
  logic [CW-1:0]        div_cnt_q;
  logic [DIV_W-1:0]     quo_q;
  logic [ACC_BITS-1:0]  rem_q;
  logic [ACC_BITS-1:0]  dvs_q;
  logic                 neg_q;

  function automatic logic signed [PW-1:0] sx(input logic signed [ACC_BITS-1:0] v);
    return {{ACC_BITS{v[ACC_BITS-1]}}, v};
  endfunction

  // Loop indexing helpers
  logic [IW:0]   row_nx, col_nx;
  logic          row_last, col_end, k_last, scan_last;
  logic [IW-1:0] first_idx, k_nx;

  // Row/column iteration: rows skip k, columns skip k and jump from n-1 to b at N
  always_comb begin
    row_nx = {1'b0, i_q} + (IW+1)'(1);
    if (row_nx == {1'b0, k_q}) row_nx = row_nx + (IW+1)'(1);
    row_last = (row_nx >= {1'b0, n_q});
    col_nx = {1'b0, j_q} + (IW+1)'(1);
    if (col_nx == {1'b0, k_q}) col_nx = col_nx + (IW+1)'(1);
    if (col_nx >= {1'b0, n_q}) col_nx = (IW+1)'(N);
    col_end   = (j_q == IW'(N));
    first_idx = (k_q == '0) ? IW'(1) : '0;
    k_nx      = k_q + IW'(1);
    k_last    = (k_nx == n_q);
    scan_last = (scan_q == n_q - IW'(1));
  end

  // Pivot search: strict compare keeps the lowest row on ties
  logic signed [ACC_BITS-1:0] cur_val;
  logic [ACC_BITS-1:0]        cur_mag, fin_mag;
  logic [IW-1:0]              fin_row;
  logic                       cand;

  always_comb begin
    cur_val = a_q[scan_q][k_q];
    cur_mag = cur_val[ACC_BITS-1] ? -cur_val : cur_val;
    cand    = (scan_q >= k_q) && (cur_mag > best_mag_q);
    fin_mag = cand ? cur_mag : best_mag_q;
    fin_row = cand ? scan_q : best_row_q;
  end

  // Divider operands and one restoring step
  logic signed [PW-1:0]       num;
  logic signed [ACC_BITS-1:0] den;
  logic [PW-1:0]              num_mag;
  logic [ACC_BITS-1:0]        den_mag;
  logic [ACC_BITS:0]          rem_sh, rem_nx;
  logic                       ge;
  logic [DIV_W-1:0]           quo_nx;
  logic [ACC_BITS-1:0]        quo_lo, div_res;
  logic                       div_load, div_wb;
  logic                       unused_bits;

  always_comb begin
    if (state_q == StSolve) begin
      num = sx(a_q[i_q][N]) <<< FRAC_BITS;
      den = a_q[i_q][i_q];
    end else begin
      num = sx(a_q[k_q][k_q]) * sx(a_q[i_q][j_q]) - sx(a_q[i_q][k_q]) * sx(a_q[k_q][j_q]);
      den = prev_piv_q;
    end
    num_mag = num[PW-1] ? -num : num;
    den_mag = den[ACC_BITS-1] ? -den : den;
    rem_sh  = {rem_q, quo_q[DIV_W-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
    quo_nx  = {quo_q[DIV_W-2:0], ge};
    quo_lo  = quo_q[ACC_BITS-1:0];
    div_res = neg_q ? -quo_lo : quo_lo;
    div_load = (div_cnt_q == '0);
    div_wb   = (div_cnt_q == CW'(D - 1));
  end

  // Remainder never exceeds the divisor, and numerators fit in DIV_W by contract
  assign unused_bits = ^{num_mag[PW-1:DIV_W], rem_nx[ACC_BITS]};

  // Control FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  state_d = StPivot;
      StPivot: if (scan_last) state_d = (fin_mag == '0) ? StDone : StSwap;
      StSwap:  state_d = StElim;
      StElim:  if (div_wb && col_end && row_last) state_d = k_last ? StSolve : StPivot;
      StSolve: if (div_wb && (i_q == n_q - IW'(1))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Datapath: matrix, pivot search, divider and results
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c <= N; c++) a_q[r][c] <= '0;
      end
      prev_piv_q <= '0;
      n_q        <= IW'(N);
      k_q        <= '0;
      scan_q     <= '0;
      best_row_q <= '0;
      best_mag_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      sing_q     <= 1'b0;
      x_q        <= '0;
      div_cnt_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            n_q <= (size_i >= IW'(2) && size_i <= IW'(N)) ? size_i : IW'(N);
          end
        end
        StLoad: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c <= N; c++) begin
              a_q[r][c] <= {{(ACC_BITS-DATA_BITS){mat_i[r][c][DATA_BITS-1]}}, mat_i[r][c]};
            end
          end
          prev_piv_q <= ACC_BITS'(1);
          k_q        <= '0;
          scan_q     <= '0;
          best_mag_q <= '0;
          best_row_q <= '0;
          sing_q     <= 1'b0;
          x_q        <= '0;
        end
        StPivot: begin
          scan_q     <= scan_q + IW'(1);
          best_mag_q <= fin_mag;
          best_row_q <= fin_row;
          if (scan_last && (fin_mag == '0)) sing_q <= 1'b1;
        end
        StSwap: begin
          if (best_row_q != k_q) begin
            for (int c = 0; c <= N; c++) begin
              a_q[k_q][c]        <= a_q[best_row_q][c];
              a_q[best_row_q][c] <= a_q[k_q][c];
            end
          end
          i_q       <= first_idx;
          j_q       <= first_idx;
          div_cnt_q <= '0;
        end
        StElim, StSolve: begin
          if (div_load) begin
            quo_q     <= num_mag[DIV_W-1:0];
            rem_q     <= '0;
            dvs_q     <= den_mag;
            neg_q     <= num[PW-1] ^ den[ACC_BITS-1];
            div_cnt_q <= div_cnt_q + CW'(1);
          end else if (!div_wb) begin
            quo_q     <= quo_nx;
            rem_q     <= rem_nx[ACC_BITS-1:0];
            div_cnt_q <= div_cnt_q + CW'(1);
          end else begin
            div_cnt_q <= '0;
            if (state_q == StElim) begin
              a_q[i_q][j_q] <= div_res;
              if (col_end) begin
                // a[i][k] feeds every column of this row, so clear it only at the end
                a_q[i_q][k_q] <= '0;
                if (row_last) begin
                  prev_piv_q <= a_q[k_q][k_q];
                  k_q        <= k_nx;
                  scan_q     <= '0;
                  best_mag_q <= '0;
                  best_row_q <= '0;
                  i_q        <= '0;
                end else begin
                  i_q <= row_nx[IW-1:0];
                  j_q <= first_idx;
                end
              end else begin
                j_q <= col_nx[IW-1:0];
              end
            end else begin
              x_q[i_q] <= div_res;
              i_q      <= i_q + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign done_o     = (state_q == StDone);
  assign singular_o = sing_q;
  assign x_o        = x_q;

endmodule

// File: doc/ame_linear_solver.md
# ame_linear_solver

Sequential, parametrised N×N linear-system solver for the affine motion estimation (AME) path. It solves A·x = b with fraction-free (Bareiss) Gauss-Jordan elimination, partial pivoting and exact integer division. Results are signed fixed point. The active system size is selected at run time, so one instance serves the 4-parameter and 6-parameter affine models and larger N, and the block reports singular systems.

## Interface
- N, 6, maximum system dimension (≥2)
- DATA_BITS, 32, signed width of each input coefficient
- ACC_BITS, 64, signed width of internal matrix registers and of results
- FRAC_BITS, 16, fractional bits of each result
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  start request; accepted only when ready_o=1
- size_i  in  $clog2(N+1)  active dimension n; 2..N; any other value is treated as N
- mat_i  in  N×(N+1)×DATA_BITS  row r: A[r][0..N-1], b[r] at column N; only rows/cols <n used
- ready_o  out  1  idle, will accept start_i
- done_o  out  1  one-cycle pulse when results are valid
- singular_o  out  1  set with done_o if a zero pivot column was found; held until next start
- x_o  out  N×ACC_BITS  x[i] = round-toward-zero(b'_i·2^FRAC_BITS / a'_ii), low ACC_BITS bits; entries ≥n are 0

## Operation
- States: IDLE → LOAD → PIVOT → SWAP → ELIM → (next k: PIVOT | all k done: SOLVE) → DONE → IDLE.
- IDLE: ready_o=1. start_i=1 latches size_i into n. While not IDLE, start_i is ignored.
- LOAD (1 cycle): sign-extend mat_i into ACC_BITS registers. Set prev_piv=1, k=0, singular_o=0, x_o=0.
- PIVOT (n cycles, fixed): scan rows 0..n-1 and consider only rows ≥k. Select the largest |a[r][k]|; on ties, the lowest r wins. If the maximum is 0: singular_o=1, x_o stays 0, go to DONE.
- SWAP (1 cycle): exchange row k with the pivot row. Perform a no-op if they are the same row.
- ELIM: for each row i≠k in ascending order, for each column j∈{0..n-1, N}\{k} in ascending order: a[i][j] ← (a[k][k]·a[i][j] − a[i][k]·a[k][j]) / prev_piv.
  - The division is exact and uses the shared serial divider.
  - Column k of row i is written 0 together with that row's last column.
  - Row k is untouched.
  - After ELIM: prev_piv ← a[k][k], k ← k+1.
- SOLVE: for i = 0..n-1, x[i] ← (b[i]·2^FRAC_BITS)/a[i][i], signed, truncated toward zero. After elimination all a[i][i] are equal (±det).
- DONE (1 cycle): done_o=1, return to IDLE. x_o and singular_o hold until the next accepted start.
- Arithmetic:
  - Products are formed at 2·ACC_BITS, and the division result is truncated to ACC_BITS.
  - The caller guarantees that all intermediates fit in ACC_BITS signed. Overflow wraps and is not flagged.
- Divider: one restoring divider, DIV_W = ACC_BITS+FRAC_BITS. It operates on magnitudes and applies sign afterwards. Every division takes D = DIV_W+2 cycles (load, DIV_W iterations, writeback).

## Timing
- Reset values: ready_o=1, done_o=0, singular_o=0, x_o=0. State returns to IDLE and all matrix registers are 0.
- Reset asserted mid-operation: immediate abort to the reset values above. No done_o is issued.
- Latency is data-independent for non-singular input.
  - Measured from the start_i cycle to the done_o cycle: L = 2 + n·(n+1) + n·n·(n−1)·D + n·D.
  - Default parameters, n=2: D=82, L = 2+6+328+164 = 500.
- Singular input: done_o is asserted 1 cycle after the PIVOT pass that finds the zero column.
- ready_o falls in the cycle after start_i is accepted. It rises in the cycle after done_o.
- start_i asserted in the same cycle as done_o is ignored. A new start is accepted from the next cycle on.

## Test plan
- n=2, A=[[2,1],[1,3]], b=[3,5] -> x=[52428, 91750], singular_o=0, done_o exactly 500 cycles after start.
- n=2, A=[[0,1],[1,0]], b=[7,9] (pivot swap) -> x=[589824, 458752].
- n=2, A=[[3,0],[0,3]], b=[-1,1] -> x=[-21845, 21845] (truncation toward zero).
- n=3, A=I, b=[1,-2,3] -> x=[65536,-131072,196608], x[3..5]=0. Repeat with size_i=0 so n=N=6 and A=I, b=1..6 -> x=k·65536.
- n=2, A=[[1,2],[2,4]] -> singular_o=1, x_o all 0. done_o follows the second PIVOT pass. The next start with a valid matrix clears singular_o.
- Run the first case and assert rst_n_i=0 mid-ELIM -> outputs at reset values, no done_o. Restart and get an identical result. A start_i pulse while busy has no effect.
